serial_tx_arbiter: RTL and testbench

N-channel byte arbiter that merges independent byte producers (UART RX echo, test-pattern generators, debug taps) onto a single byte sink such as the USB-serial TX port or uart_tx. Each channel has its own parametrised synchronous FIFO. A round-robin scheduler drains the FIFOs through a ready/strobe handshake. It replaces the hand-wired single FIFO plus gating logic in the serial top level.

---
 rtl/serial_tx_arbiter_pkg.sv | 26 ++
 rtl/serial_tx_arbiter_fifo.sv | 86 ++++++++
 rtl/serial_tx_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_serial_tx_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_tx_arbiter_pkg.sv
// serial_tx_arbiter_pkg
//   Shared definitions for the serial TX arbiter and its per-channel FIFO:
//   FSM state encodings, a clog2 helper and the default tag base byte.
//   Optional feature macro (used by serial_tx_arbiter): SERIAL_TX_ARBITER_TAG_EN.
package serial_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TAG  = 2'd1,
    S_SEND = 2'd2,
    S_HOLD = 2'd3
  } arb_state_e;

  localparam logic [7:0] TAG_BASE_DEFAULT = 8'hF0;

  // Number of bits needed to index 'value' entries (clog2(1) = 0).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_tx_arbiter_fifo.sv
// byte_fifo
//   Synchronous single-clock FIFO, DEPTH entries of WIDTH bits (DEPTH a power
//   of two, >= 2). Head of queue is presented combinationally on read_data.
// Ports:
//   clk_48mhz, reset      clock, synchronous active-high reset
//   write_data/strobe     push; dropped (and overflow set) when full
//   read_data/strobe      head of queue / pop; ignored when empty
//   full, empty           registered occupancy flags
//   overflow              sticky until reset; a push was dropped
module byte_fifo
  import serial_tx_arbiter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk_48mhz,
  input  logic             reset,
  input  logic [WIDTH-1:0] write_data,
  input  logic             write_strobe,
  output logic [WIDTH-1:0] read_data,
  input  logic             read_strobe,
  output logic             full,
  output logic             empty,
  output logic             overflow
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             overflow_q, overflow_d;
  logic             wr_en, rd_en;

  always_comb begin
    // A push on a full FIFO is dropped even when a pop happens this cycle.
    wr_en      = write_strobe && !full_q;
    rd_en      = read_strobe && !empty_q;
    wr_ptr_d   = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = rd_en ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d    = count_q;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    full_d     = (count_d == CW'(DEPTH));
    empty_d    = (count_d == '0);
    overflow_d = overflow_q | (write_strobe & full_q);
  end

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is not reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk_48mhz) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= write_data;
    end
  end

  assign read_data = mem_q[rd_ptr_q];
  assign full      = full_q;
  assign empty     = empty_q;
  assign overflow  = overflow_q;

endmodule

// File: rtl/serial_tx_arbiter.sv
// serial_tx_arbiter
//   Merges CHANNELS independent byte producers onto one byte sink. Each channel
//   has its own byte_fifo; a round-robin FSM drains them one byte at a time.
//   Optional macro SERIAL_TX_ARBITER_TAG_EN: emit TAG_BASE | channel before a
//   byte whenever the served channel differs from the previous one.
// Ports:
//   clk_48mhz, reset   clock, synchronous active-high reset
//   in_data/in_strobe  per-channel byte and one-cycle write pulse
//   in_ready           per-channel FIFO not full (registered)
//   overflow           per-channel sticky dropped-write flag
//   out_ready          sink can accept a byte
//   out_data/strobe    byte to sink, valid during the one-cycle strobe
//   busy               any FIFO non-empty or FSM not idle
//   dbg_state          current FSM state
// Handshake: a byte moves to the sink only on a cycle where out_strobe is high;
//   out_strobe is raised only after out_ready was sampled high in SEND/TAG, and
//   every strobe is followed by one idle gap cycle (HOLD) because the sink may
//   lower out_ready one cycle late.
module serial_tx_arbiter
  import serial_tx_arbiter_pkg::*;
#(
  parameter int               CHANNELS = 2,
  parameter int               WIDTH    = 8,
  parameter int               DEPTH    = 16,
  parameter logic [WIDTH-1:0] TAG_BASE = WIDTH'(TAG_BASE_DEFAULT)
) (
  input  logic                      clk_48mhz,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_strobe,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [CHANNELS-1:0]       overflow,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_strobe,
  output logic                      busy,
  output logic [1:0]                dbg_state
);

  localparam int CH_W = (CHANNELS > 1) ? clog2(CHANNELS) : 1;

  logic [WIDTH-1:0]    head [CHANNELS];
  logic [CHANNELS-1:0] fifo_full, fifo_empty, fifo_pop;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_fifo
    byte_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk_48mhz    (clk_48mhz),
      .reset        (reset),
      .write_data   (in_data[c*WIDTH +: WIDTH]),
      .write_strobe (in_strobe[c]),
      .read_data    (head[c]),
      .read_strobe  (fifo_pop[c]),
      .full         (fifo_full[c]),
      .empty        (fifo_empty[c]),
      .overflow     (overflow[c])
    );
  end

  arb_state_e       state_q, state_d;
  logic [CH_W-1:0]  ptr_q, ptr_d;
  logic [CH_W-1:0]  grant_q, grant_d;
  logic             out_strobe_q, out_strobe_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
`ifdef SERIAL_TX_ARBITER_TAG_EN
  logic [CH_W-1:0]  last_ch_q, last_ch_d;
  logic             last_valid_q, last_valid_d;
  logic             after_tag_q, after_tag_d;
`endif

  logic             any_valid;
  logic [CH_W-1:0]  next_grant;
  logic             pop;
  logic [WIDTH-1:0] send_byte;
  int               idx;

  // Round-robin search: first non-empty channel starting at ptr+1. The loop
  // runs from the farthest candidate down, so the nearest one wins.
  always_comb begin
    any_valid  = 1'b0;
    next_grant = ptr_q;
    idx        = 0;
    for (int i = CHANNELS; i >= 1; i--) begin
      idx = int'(ptr_q) + i;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (!fifo_empty[CH_W'(idx)]) begin
        any_valid  = 1'b1;
        next_grant = CH_W'(idx);
      end
    end
  end

  // Byte presented in TAG is the channel tag, otherwise the granted head.
  assign send_byte = (state_q == S_TAG) ? (TAG_BASE | WIDTH'(grant_q)) : head[grant_q];

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    grant_d      = grant_q;
    out_strobe_d = 1'b0;
    out_data_d   = out_data_q;
    pop          = 1'b0;
`ifdef SERIAL_TX_ARBITER_TAG_EN
    last_ch_d    = last_ch_q;
    last_valid_d = last_valid_q;
    after_tag_d  = after_tag_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (any_valid) begin
          grant_d = next_grant;
          ptr_d   = next_grant;
`ifdef SERIAL_TX_ARBITER_TAG_EN
          if (!last_valid_q || (next_grant != last_ch_q)) state_d = S_TAG;
          else                                            state_d = S_SEND;
`else
          state_d = S_SEND;
`endif
        end
      end
`ifdef SERIAL_TX_ARBITER_TAG_EN
      S_TAG: begin
        if (out_ready) begin
          out_strobe_d = 1'b1;
          out_data_d   = send_byte;
          after_tag_d  = 1'b1;
          state_d      = S_HOLD;
        end
      end
`endif
      S_SEND: begin
        if (out_ready) begin
          out_strobe_d = 1'b1;
          out_data_d   = send_byte;
          pop          = 1'b1;
`ifdef SERIAL_TX_ARBITER_TAG_EN
          last_ch_d    = grant_q;
          last_valid_d = 1'b1;
          after_tag_d  = 1'b0;
`endif
          state_d      = S_HOLD;
        end
      end
      S_HOLD: begin
`ifdef SERIAL_TX_ARBITER_TAG_EN
        // After a tag the data byte of the same grant follows directly.
        state_d     = after_tag_q ? S_SEND : S_IDLE;
        after_tag_d = 1'b0;
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    fifo_pop = '0;
    if (pop) fifo_pop[grant_q] = 1'b1;
  end

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      state_q      <= S_IDLE;
      ptr_q        <= CH_W'(CHANNELS - 1);
      grant_q      <= '0;
      out_strobe_q <= 1'b0;
      out_data_q   <= '0;
`ifdef SERIAL_TX_ARBITER_TAG_EN
      last_ch_q    <= '0;
      last_valid_q <= 1'b0;
      after_tag_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      grant_q      <= grant_d;
      out_strobe_q <= out_strobe_d;
      out_data_q   <= out_data_d;
`ifdef SERIAL_TX_ARBITER_TAG_EN
      last_ch_q    <= last_ch_d;
      last_valid_q <= last_valid_d;
      after_tag_q  <= after_tag_d;
`endif
    end
  end

  assign in_ready   = ~fifo_full;
  assign out_strobe = out_strobe_q;
  assign out_data   = out_data_q;
  assign busy       = (~&fifo_empty) | (state_q != S_IDLE);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// tb_serial_tx_arbiter
//   Directed bench for serial_tx_arbiter (CHANNELS=2, WIDTH=8, DEPTH=16):
//   a cycle-by-cycle vector table for latency/throughput, then hand-written
//   sequences for fairness, overflow, backpressure and reset mid-operation.
module tb_serial_tx_arbiter;

  localparam int CHANNELS = 2;
  localparam int WIDTH    = 8;
  localparam int DEPTH    = 16;

  // Clock / reset
  logic                      clk_48mhz = 1'b0;
  logic                      reset     = 1'b1;
  logic [CHANNELS*WIDTH-1:0] in_data   = '0;
  logic [CHANNELS-1:0]       in_strobe = '0;
  logic [CHANNELS-1:0]       in_ready;
  logic [CHANNELS-1:0]       overflow;
  logic                      out_ready = 1'b0;
  logic [WIDTH-1:0]          out_data;
  logic                      out_strobe;
  logic                      busy;
  logic [1:0]                dbg_state;

  always #10 clk_48mhz = ~clk_48mhz;

  serial_tx_arbiter #(
    .CHANNELS (CHANNELS),
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH)
  ) dut (
    .clk_48mhz  (clk_48mhz),
    .reset      (reset),
    .in_data    (in_data),
    .in_strobe  (in_strobe),
    .in_ready   (in_ready),
    .overflow   (overflow),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_strobe (out_strobe),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // Scoreboard
  int               checks     = 0;
  int               errors     = 0;
  int               strobe_cnt = 0;
  int               tb_last_ch = -1;
  logic             mon_en     = 1'b0;
  logic             prev_strobe = 1'b0;
  logic [WIDTH-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Expected sink stream, including channel tags when the feature is built in.
  task automatic expect_byte(input int ch, input logic [7:0] b);
`ifdef SERIAL_TX_ARBITER_TAG_EN
    if (ch != tb_last_ch) exp_q.push_back(8'hF0 | 8'(ch));
`endif
    tb_last_ch = ch;
    exp_q.push_back(b);
  endtask

  always @(negedge clk_48mhz) begin
    if (out_strobe) begin
      strobe_cnt++;
      if (mon_en) begin
        checks++;
        if (prev_strobe) begin
          errors++;
          $display("FAIL strobe_width got=2_cycles expected=1_cycle");
        end else if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL stream_extra got=%0h expected=no_strobe", out_data);
        end else begin
          logic [WIDTH-1:0] e;
          e = exp_q.pop_front();
          if (out_data !== e) begin
            errors++;
            $display("FAIL stream_byte got=%0h expected=%0h", out_data, e);
          end
        end
      end
    end
    prev_strobe = out_strobe;
  end

  // Driver tasks
  task automatic step();
    @(posedge clk_48mhz);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    in_strobe  = '0;
    in_data    = '0;
    step();
    step();
    reset      = 1'b0;
    tb_last_ch = -1;
    exp_q.delete();
  endtask

  task automatic write_cycle(input logic [1:0] st, input logic [7:0] d0, input logic [7:0] d1);
    in_strobe = st;
    in_data   = {d1, d0};
    step();
    in_strobe = '0;
    in_data   = '0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 400) begin
      step();
      n++;
    end
    check({name, "_left"}, exp_q.size(), 0);
    check({name, "_busy"}, busy, 1'b0);
  endtask

  // Cycle table: inputs applied before an edge, outputs checked just after it.
  typedef struct {
    logic [1:0]  in_strobe;
    logic [15:0] in_data;
    logic        out_ready;
    logic        exp_strobe;
    logic [7:0]  exp_data;
    logic [1:0]  exp_in_ready;
    logic        exp_busy;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
`ifdef SERIAL_TX_ARBITER_TAG_EN
    vecs[0] = '{2'b01, 16'h0041, 1'b1, 1'b0, 8'h00, 2'b11, 1'b1};
    vecs[1] = '{2'b01, 16'h0042, 1'b1, 1'b0, 8'h00, 2'b11, 1'b1};
    vecs[2] = '{2'b00, 16'h0000, 1'b1, 1'b1, 8'hF0, 2'b11, 1'b1};
    vecs[3] = '{2'b00, 16'h0000, 1'b1, 1'b0, 8'hF0, 2'b11, 1'b1};
    vecs[4] = '{2'b00, 16'h0000, 1'b1, 1'b1, 8'h41, 2'b11, 1'b1};
    vecs[5] = '{2'b00, 16'h0000, 1'b1, 1'b0, 8'h41, 2'b11, 1'b1};
    vecs[6] = '{2'b00, 16'h0000, 1'b1, 1'b0, 8'h41, 2'b11, 1'b1};
    vecs[7] = '{2'b00, 16'h0000, 1'b1, 1'b1, 8'h42, 2'b11, 1'b1};
    vecs[8] = '{2'b00, 16'h0000, 1'b1, 1'b0, 8'h42, 2'b11, 1'b0};
    vecs[9] = '{2'b00, 16'h0000, 1'b1, 1'b0, 8'h42, 2'b11, 1'b0};
`else
    vecs[0] = '{2'b01, 16'h0041, 1'b1, 1'b0, 8'h00, 2'b11, 1'b1};
    vecs[1] = '{2'b01, 16'h0042, 1'b1, 1'b0, 8'h00, 2'b11, 1'b1};
    vecs[2] = '{2'b00, 16'h0000, 1'b1, 1'b1, 8'h41, 2'b11, 1'b1};
    vecs[3] = '{2'b00, 16'h0000, 1'b1, 1'b0, 8'h41, 2'b11, 1'b1};
    vecs[4] = '{2'b00, 16'h0000, 1'b1, 1'b0, 8'h41, 2'b11, 1'b1};
    vecs[5] = '{2'b00, 16'h0000, 1'b1, 1'b1, 8'h42, 2'b11, 1'b1};
    vecs[6] = '{2'b00, 16'h0000, 1'b1, 1'b0, 8'h42, 2'b11, 1'b0};
    vecs[7] = '{2'b00, 16'h0000, 1'b1, 1'b0, 8'h42, 2'b11, 1'b0};
    vecs[8] = '{2'b00, 16'h0000, 1'b1, 1'b0, 8'h42, 2'b11, 1'b0};
    vecs[9] = '{2'b00, 16'h0000, 1'b1, 1'b0, 8'h42, 2'b11, 1'b0};
`endif

    // Reset then idle with the sink ready.
    do_reset();
    out_ready = 1'b1;
    check("reset_out_data", out_data, 8'h00);
    check("reset_overflow", overflow, 2'b00);
    for (int i = 0; i < 20; i++) begin
      step();
      check("idle_strobe", out_strobe, 1'b0);
    end
    check("idle_in_ready", in_ready, 2'b11);
    check("idle_busy", busy, 1'b0);

    // Latency and 3-cycle spacing table.
    for (int i = 0; i < NV; i++) begin
      in_strobe = vecs[i].in_strobe;
      in_data   = vecs[i].in_data;
      out_ready = vecs[i].out_ready;
      step();
      in_strobe = '0;
      in_data   = '0;
      check("vec_strobe",   out_strobe, vecs[i].exp_strobe);
      check("vec_data",     out_data,   vecs[i].exp_data);
      check("vec_in_ready", in_ready,   vecs[i].exp_in_ready);
      check("vec_busy",     busy,       vecs[i].exp_busy);
    end

    // Fairness: ch0 A,B,C and ch1 x,y written back-to-back.
    do_reset();
    out_ready = 1'b1;
    mon_en    = 1'b1;
    expect_byte(0, "A");
    expect_byte(1, "x");
    expect_byte(0, "B");
    expect_byte(1, "y");
    expect_byte(0, "C");
    write_cycle(2'b11, "A", "x");
    write_cycle(2'b11, "B", "y");
    write_cycle(2'b01, "C", 8'h00);
    wait_drain("fair");

    // Overflow on ch1 with the sink stalled.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      write_cycle(2'b10, 8'h00, 8'(8'h10 + i));
      if (i == 14) check("ovf_ready_15", in_ready, 2'b11);
      if (i == 15) begin
        check("ovf_ready_16", in_ready, 2'b01);
        check("ovf_flag_16", overflow, 2'b00);
      end
      if (i == 16) begin
        check("ovf_ready_17", in_ready, 2'b01);
        check("ovf_flag_17", overflow, 2'b10);
      end
    end
    for (int i = 0; i < 16; i++) expect_byte(1, 8'(8'h10 + i));
    out_ready = 1'b1;
    wait_drain("ovf_drain");
    check("ovf_sticky", overflow, 2'b10);
    check("ovf_ready_after", in_ready, 2'b11);

    // Backpressure mid-stream for 50 cycles.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      expect_byte(0, 8'(8'h20 + i));
      expect_byte(1, 8'(8'h30 + i));
    end
    for (int i = 0; i < 4; i++) write_cycle(2'b11, 8'(8'h20 + i), 8'(8'h30 + i));
    repeat (8) step();
    out_ready = 1'b0;
    step();
    begin
      int snap;
      snap = strobe_cnt;
      repeat (49) step();
      check("bp_no_strobe", strobe_cnt, snap);
      check("bp_busy", busy, 1'b1);
    end
    out_ready = 1'b1;
    wait_drain("bp_drain");

    // Reset mid-operation: queued bytes and overflow are discarded.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 17; i++) write_cycle(2'b01, 8'(8'h60 + i), 8'h00);
    write_cycle(2'b10, 8'h00, 8'h70);
    check("rst_pre_overflow", overflow, 2'b01);
    begin
      int snap;
      snap      = strobe_cnt;
      out_ready = 1'b1;
      reset     = 1'b1;
      step();
      reset     = 1'b0;
      tb_last_ch = -1;
      check("rst_busy", busy, 1'b0);
      check("rst_overflow", overflow, 2'b00);
      check("rst_in_ready", in_ready, 2'b11);
      check("rst_strobe", out_strobe, 1'b0);
      repeat (10) step();
      check("rst_no_strobe", strobe_cnt, snap);
    end
    expect_byte(1, 8'h55);
    write_cycle(2'b10, 8'h00, 8'h55);
    wait_drain("rst_fresh");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
